// File: rtl/insn_fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory
// and holds it in INSN/PC until the decoder consumes it.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | one cycle after reset before the first request
// S_FETCH | request outstanding at fetch_pc, counting wait cycles
// S_HOLD  | INSN/PC valid, waiting for insn_ready
// S_FAULT | sticky fault (timeout or misaligned redirect), no requests
module insn_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] INSN,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] PC,
    output logic        fetch_fault
);

    localparam int unsigned   CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   insn_q, insn_d;
    logic [31:0]   pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            insn_q     <= NOP;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            insn_q     <= insn_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        insn_d     = insn_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        if (redirect) begin
            // Redirect beats everything; a response landing this cycle is dropped.
            fetch_pc_d = redirect_pc;
            valid_d    = 1'b0;
            cnt_d      = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = S_FETCH;
                fault_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        insn_d     = mem_rdata;
                        pc_d       = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        cnt_d      = '0;
                        state_d    = S_HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (insn_ready && valid_q) begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FAULT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = (state_q == S_FETCH);
    assign mem_addr    = fetch_pc_q;
    assign INSN        = insn_q;
    assign PC          = pc_q;
    assign insn_valid  = valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: directed scenarios then randomized traffic, checked
// against a transaction-level model and an instruction scoreboard.
module tb_insn_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 15;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] INSN;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] PC;
    logic        fetch_fault;

    insn_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .INSN(INSN), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .PC(PC), .fetch_fault(fetch_fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the fetcher is doing this cycle.
    logic        m_boot    = 1'b1;  // first cycle after reset, no request yet
    logic        m_req     = 1'b0;  // a request should be outstanding
    logic        m_held    = 1'b0;  // an instruction is waiting for the decoder
    logic        m_fault   = 1'b0;
    logic [31:0] m_addr    = RST_PC;
    int          m_stalled = 0;
    logic [31:0] m_insn    = NOP;
    logic [31:0] m_pc      = RST_PC;
    logic        mon_en    = 1'b0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Applies the rules to the inputs seen at this rising edge.
    task automatic model_update();
        if (!RST_N) begin
            m_boot = 1'b1; m_req = 1'b0; m_held = 1'b0; m_fault = 1'b0;
            m_addr = RST_PC; m_stalled = 0; m_insn = NOP; m_pc = RST_PC;
            sb_q.delete();
        end else if (redirect) begin
            m_boot = 1'b0; m_held = 1'b0; m_stalled = 0;
            m_addr = redirect_pc;
            m_fault = (redirect_pc % 4) != 0;
            m_req = !m_fault;
        end else if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1;
        end else if (m_fault) begin
            m_req = 1'b0;
        end else if (m_req) begin
            if (mem_ready) begin
                sb_q.push_back('{pc: m_addr, insn: mem_rdata});
                m_insn = mem_rdata; m_pc = m_addr;
                m_addr = 32'((64'(m_addr) + 64'd4) % 64'h1_0000_0000);
                m_held = 1'b1; m_req = 1'b0; m_stalled = 0;
            end else begin
                m_stalled++;
                if (m_stalled == TMO + 1) begin
                    m_fault = 1'b1; m_req = 1'b0; m_stalled = 0;
                end
            end
        end else if (m_held && insn_ready) begin
            m_held = 1'b0; m_req = 1'b1;
        end
        mon_en = 1'b1;
    endtask

    // Memory only answers when a request is expected to be outstanding.
    task automatic cyc(input logic rst_n, input logic red, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rd, input logic irdy);
        RST_N = rst_n; redirect = red; redirect_pc = rpc;
        mem_ready = rdy & m_req; mem_rdata = rd; insn_ready = irdy;
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) chk("mem_addr", mem_addr, m_addr);
            chk("insn_valid", 32'(insn_valid), 32'(m_held));
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            if (insn_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got INSN %h PC %h expected no instruction", INSN, PC);
                end else begin
                    cur = sb_q.pop_front();
                    chk("sb_insn", INSN, cur.insn);
                    chk("sb_pc", PC, cur.pc);
                end
            end else if (insn_valid) begin
                chk("hold_insn", INSN, cur.insn);
                chk("hold_pc", PC, cur.pc);
            end else begin
                chk("idle_insn", INSN, m_insn);
                chk("idle_pc", PC, m_pc);
            end
            prev_valid = insn_valid;
        end
    end

    logic [31:0] tmp, rpc, data;
    int r, k;

    initial begin
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge CLK);
        chk("rst_insn", INSN, NOP);
        chk("rst_pc", PC, RST_PC);

        // First fetch with one wait cycle.
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 32'h0000_00B3, 1'b0);
        @(negedge CLK);
        chk("first_insn", INSN, 32'h0000_00B3);
        chk("first_valid", 32'(insn_valid), 32'd1);

        // Decoder stalls 5 cycles, then consumes.
        idle(5);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge CLK);
        chk("next_addr", mem_addr, 32'h4);

        // Timeout, then recovery by aligned redirect.
        idle(TMO + 1);
        @(negedge CLK);
        chk("tmo_fault", 32'(fetch_fault), 32'd1);
        chk("tmo_req", 32'(mem_req), 32'd0);
        cyc(1'b1, 1'b1, 32'h100, 1'b0, '0, 1'b0);
        @(negedge CLK);
        chk("redir_addr", mem_addr, 32'h100);

        // Redirect collides with a response.
        cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge CLK);
        chk("coll_addr", mem_addr, 32'h200);
        chk("coll_insn", INSN, 32'h0000_00B3);

        // Misaligned redirect, then wrap at the top of the address space.
        cyc(1'b1, 1'b1, 32'h0000_0102, 1'b0, '0, 1'b0);
        @(negedge CLK);
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 32'h1234_5678, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge CLK);
        chk("wrap_addr", mem_addr, 32'h0);
        chk("wrap_pc", PC, 32'hFFFF_FFFC);

        // Reset pulse in the middle of a fetch wait.
        idle(2);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge CLK);
        chk("mid_rst_insn", INSN, NOP);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        idle(1);
        @(negedge CLK);
        chk("restart_addr", mem_addr, RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            tmp = $urandom();
            k = $urandom_range(0, 9);
            rpc = (k == 0) ? tmp : (k == 1) ? 32'hFFFF_FFFC : (k == 2) ? 32'hFFFF_FFF8
                  : (tmp & 32'hFFFF_FFFC);
            data = $urandom();
            cyc((r >= 3) ? 1'b1 : 1'b0, (r >= 3 && r < 50) ? 1'b1 : 1'b0, rpc,
                ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, data,
                ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0);
        end

        idle(3);
        @(negedge CLK);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
